key_buffer_reader: RTL and testbench

//  Drain side of the keypoint buffer: on i_start, pops entries from the buffer head with a one-cycle next pulse.

---
 rtl/key_buffer_reader.sv | 170 +++++++++++++++++
 tb/tb_key_buffer_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_buffer_reader.sv
// Drain side of the keypoint buffer: pops head entries, drops empty slots, hands kept keypoints to the matcher.
// Optional build macro KEY_DEPTH_FILTER_EN also drops entries that carry no depth (i_depth == 0).
module key_buffer_reader #(
    parameter int SIZE   = 10,
    parameter int MAX_KP = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_buf_flag,
    input  logic [9:0]   i_coor_x,
    input  logic [9:0]   i_coor_y,
    input  logic [7:0]   i_score,
    input  logic [255:0] i_descriptor,
    input  logic [9:0]   i_depth,
    output logic         o_next,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [9:0]   o_coor_x,
    output logic [9:0]   o_coor_y,
    output logic [7:0]   o_score,
    output logic [255:0] o_descriptor,
    output logic [9:0]   o_depth,
    output logic [9:0]   o_count,
    output logic         o_busy,
    output logic         o_done,
    output logic [1:0]   o_state
);

    // Handshake: a keypoint transfers on a clock edge where o_valid & i_ready; while o_valid is
    // high the o_* data never changes, and o_valid only drops after the transfer.

    localparam logic [9:0] SIZE_W   = 10'(SIZE);
    localparam logic [9:0] MAX_KP_W = 10'(MAX_KP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [9:0]   r_reads;
    logic [9:0]   r_count;
    logic         r_valid;
    logic [9:0]   r_coor_x;
    logic [9:0]   r_coor_y;
    logic [7:0]   r_score;
    logic [255:0] r_descriptor;
    logic [9:0]   r_depth;

    logic w_at_end;
    logic w_drop;
    logic w_next;
    logic w_capture;
    logic w_accept;
    logic w_last;

    assign w_at_end = !i_buf_flag || (r_reads == SIZE_W);

`ifdef KEY_DEPTH_FILTER_EN
    assign w_drop = (i_score == 8'd0) || (i_depth == 10'd0);
`else
    assign w_drop = (i_score == 8'd0);
`endif

    // Decided on the pre-increment count: this accept is the MAX_KP-th keypoint.
    assign w_last = ((r_count + 10'd1) == MAX_KP_W) || (r_reads == SIZE_W);

    always_comb begin
        w_state_nxt = r_state;
        w_next      = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_at_end) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_next = 1'b1;
                    if (!w_drop) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (i_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_last ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reads <= 10'd0;
            r_count <= 10'd0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_reads <= 10'd0;
                r_count <= 10'd0;
            end
            if (w_next) begin
                r_reads <= r_reads + 10'd1;
            end
            if (w_accept) begin
                r_count <= r_count + 10'd1;
            end
        end
    end

    // The head is captured on the same edge it is popped, so OUT never waits on the buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid      <= 1'b0;
            r_coor_x     <= 10'd0;
            r_coor_y     <= 10'd0;
            r_score      <= 8'd0;
            r_descriptor <= 256'd0;
            r_depth      <= 10'd0;
        end else begin
            if (w_capture) begin
                r_valid      <= 1'b1;
                r_coor_x     <= i_coor_x;
                r_coor_y     <= i_coor_y;
                r_score      <= i_score;
                r_descriptor <= i_descriptor;
                r_depth      <= i_depth;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_next       = w_next;
    assign o_valid      = r_valid;
    assign o_coor_x     = r_coor_x;
    assign o_coor_y     = r_coor_y;
    assign o_score      = r_score;
    assign o_descriptor = r_descriptor;
    assign o_depth      = r_depth;
    assign o_count      = r_count;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_state      = r_state;

endmodule

// File: tb/tb_key_buffer_reader.sv
// Bench for key_buffer_reader: behavioural shifting buffer in front, scoreboard queue behind.
module tb_key_buffer_reader;

    localparam int SIZE   = 10;
    localparam int MAX_KP = 4;
    localparam int W      = 294;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start;
    logic         ready;
    logic         buf_flag;
    logic [9:0]   cx;
    logic [9:0]   cy;
    logic [7:0]   sc;
    logic [255:0] desc;
    logic [9:0]   dep;
    logic         next;
    logic         valid;
    logic [9:0]   ox;
    logic [9:0]   oy;
    logic [7:0]   osc;
    logic [255:0] odesc;
    logic [9:0]   odep;
    logic [9:0]   ocnt;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    key_buffer_reader #(.SIZE(SIZE), .MAX_KP(MAX_KP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_buf_flag(buf_flag),
        .i_coor_x(cx), .i_coor_y(cy), .i_score(sc), .i_descriptor(desc), .i_depth(dep),
        .o_next(next), .o_valid(valid), .i_ready(ready),
        .o_coor_x(ox), .o_coor_y(oy), .o_score(osc), .o_descriptor(odesc), .o_depth(odep),
        .o_count(ocnt), .o_busy(busy), .o_done(done), .o_state(dbg_state)
    );

    // ---------------- buffer model ----------------
    logic [7:0] e_sc[16];
    logic [9:0] e_dp[16];
    int         base  = 0;
    int         n_ent = 0;
    logic [7:0] head  = 8'd0;
    int         idx;

    function automatic logic [9:0] ent_x(int i);
        return 10'(i * 37 + 5);
    endfunction
    function automatic logic [9:0] ent_y(int i);
        return 10'(i * 11 + 200);
    endfunction
    function automatic logic [255:0] ent_desc(int i);
        logic [31:0] w;
        w = (32'(i) * 32'h01010101) ^ 32'hC0DE0000;
        return {8{w}};
    endfunction
    function automatic logic [W-1:0] pack(logic [9:0] x, logic [9:0] y, logic [7:0] s,
                                          logic [9:0] d, logic [255:0] ds);
        return {x, y, s, d, ds};
    endfunction

    always_comb begin
        idx      = int'(head) - base;
        buf_flag = 1'b0;
        cx       = 10'd0;
        cy       = 10'd0;
        sc       = 8'd0;
        dep      = 10'd0;
        desc     = 256'd0;
        if (idx >= 0 && idx < n_ent && idx < 16) begin
            buf_flag = 1'b1;
            cx       = ent_x(idx);
            cy       = ent_y(idx);
            sc       = e_sc[idx[3:0]];
            dep      = e_dp[idx[3:0]];
            desc     = ent_desc(idx);
        end
    end

    always @(posedge clk) begin
        if (next) head <= head + 8'd1;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int total     = 0;
    int bad       = 0;
    int pops_cnt  = 0;
    int done_cnt  = 0;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n) begin
            if (next) begin
                pops_cnt++;
                chk("next_while_valid", W'(valid), W'(0));
            end
            if (done) done_cnt++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", W'(1), W'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("kp_data", pack(ox, oy, osc, odep, odesc), e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load(int n);
        base  = int'(head);
        n_ent = n;
    endtask

    task automatic set_entry(int i, logic [7:0] s, logic [9:0] d);
        e_sc[i[3:0]] = s;
        e_dp[i[3:0]] = d;
    endtask

    task automatic expect_entry(int i);
        exp_q.push_back(pack(ent_x(i), ent_y(i), e_sc[i[3:0]], e_dp[i[3:0]], ent_desc(i)));
    endtask

    task automatic start_drain();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_valid(string nm);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (valid) got = 1'b1;
        end
        chk({nm, "_valid_seen"}, W'(got), W'(1));
    endtask

    task automatic finish_drain(string nm, int exp_cnt, int exp_pops, int p0, int d0);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk({nm, "_done_seen"}, W'(got), W'(1));
        repeat (2) @(negedge clk);
        chk({nm, "_count"}, W'(ocnt), W'(exp_cnt));
        chk({nm, "_pops"}, W'(pops_cnt - p0), W'(exp_pops));
        chk({nm, "_done_pulses"}, W'(done_cnt - d0), W'(1));
        chk({nm, "_queue_empty"}, W'(exp_q.size()), W'(0));
        chk({nm, "_idle"}, W'(busy), W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int p0;
        int d0;
        logic [W-1:0] held;

        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 16; i++) set_entry(i, 8'd0, 10'd0);
        @(negedge clk);
        chk("rst_valid", W'(valid), W'(0));
        chk("rst_busy_done_next", W'({busy, done, next}), W'(0));
        chk("rst_data", pack(ox, oy, osc, odep, odesc), W'(0));
        chk("rst_count", W'(ocnt), W'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", W'({busy, valid, next}), W'(0));

        // T1: three keypoints, also checks start->next->valid latency
        load(3);
        set_entry(0, 8'd5, 10'd50); set_entry(1, 8'd9, 10'd51); set_entry(2, 8'd7, 10'd52);
        expect_entry(0); expect_entry(1); expect_entry(2);
        p0 = pops_cnt; d0 = done_cnt;
        start_drain();
        @(negedge clk);
        chk("t1_next_cycle1", W'(next), W'(1));
        @(negedge clk);
        chk("t1_valid_cycle2", W'(valid), W'(1));
        finish_drain("t1", 3, 3, p0, d0);

        // T2: two empty slots ahead of one keypoint
        load(3);
        set_entry(0, 8'd0, 10'd60); set_entry(1, 8'd0, 10'd61); set_entry(2, 8'd12, 10'd62);
        expect_entry(2);
        p0 = pops_cnt; d0 = done_cnt;
        start_drain();
        finish_drain("t2", 1, 3, p0, d0);

        // T3: ten keypoints, MAX_KP=4 caps the drain
        load(10);
        for (int i = 0; i < 10; i++) set_entry(i, 8'(i + 30), 10'(i + 70));
        for (int i = 0; i < 4; i++) expect_entry(i);
        p0 = pops_cnt; d0 = done_cnt;
        start_drain();
        finish_drain("t3", 4, 4, p0, d0);
        chk("t3_remaining", W'(n_ent - (int'(head) - base)), W'(6));

        // T4: downstream stalls five cycles on the first keypoint
        load(2);
        set_entry(0, 8'd44, 10'd80); set_entry(1, 8'd45, 10'd81);
        expect_entry(0); expect_entry(1);
        ready = 1'b0;
        p0 = pops_cnt; d0 = done_cnt;
        start_drain();
        wait_valid("t4");
        held = pack(ox, oy, osc, odep, odesc);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t4_stall_valid", W'(valid), W'(1));
            chk("t4_stall_data", pack(ox, oy, osc, odep, odesc), held);
            chk("t4_stall_no_next", W'(next), W'(0));
        end
        @(posedge clk); #1 ready = 1'b1;
        finish_drain("t4", 2, 2, p0, d0);

        // T5: depth 0 entry is only dropped when the depth filter is built in
        load(2);
        set_entry(0, 8'd20, 10'd0); set_entry(1, 8'd21, 10'd37);
`ifdef KEY_DEPTH_FILTER_EN
        expect_entry(1);
`else
        expect_entry(0); expect_entry(1);
`endif
        p0 = pops_cnt; d0 = done_cnt;
        start_drain();
`ifdef KEY_DEPTH_FILTER_EN
        finish_drain("t5", 1, 2, p0, d0);
`else
        finish_drain("t5", 2, 2, p0, d0);
`endif

        // T6: read limit -- eight empties then four keypoints, only SIZE pops allowed
        load(12);
        for (int i = 0; i < 8; i++) set_entry(i, 8'd0, 10'd90);
        set_entry(8, 8'd3, 10'd91); set_entry(9, 8'd4, 10'd92);
        set_entry(10, 8'd5, 10'd93); set_entry(11, 8'd6, 10'd94);
        expect_entry(8); expect_entry(9);
        p0 = pops_cnt; d0 = done_cnt;
        start_drain();
        finish_drain("t6", 2, 10, p0, d0);

        // T7: reset while a keypoint is held in OUT, then drain the rest
        load(3);
        set_entry(0, 8'd15, 10'd100); set_entry(1, 8'd16, 10'd101); set_entry(2, 8'd17, 10'd102);
        ready = 1'b0;
        p0 = pops_cnt; d0 = done_cnt;
        start_drain();
        wait_valid("t7");
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", W'(valid), W'(0));
        chk("t7_rst_busy", W'(busy), W'(0));
        chk("t7_rst_count", W'(ocnt), W'(0));
        chk("t7_rst_score", W'(osc), W'(0));
        chk("t7_rst_next", W'(next), W'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t7_no_done", W'(done_cnt - d0), W'(0));
        chk("t7_head", W'(int'(head) - base), W'(1));
        expect_entry(1); expect_entry(2);
        ready = 1'b1;
        p0 = pops_cnt; d0 = done_cnt;
        start_drain();
        finish_drain("t7", 2, 2, p0, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
